// File: rtl/xspi_flash_target.sv
// SPI/dual/quad flash responder (mode 0, MSB first) serving reads from an internal byte array.
// Define XSPI_TGT_WRITE_EN to accept 0x02 page program; otherwise memory is loaded only via load_en_i.
module xspi_flash_target #(
   parameter int MEM_DEPTH    = 256,
   parameter int ADDR_W       = 24,
   parameter int DUMMY_CYCLES = 8
) (
   input  logic                         clk_i,
   input  logic                         rst_n_i,
   input  logic                         cs_i,
   input  logic                         sclk_i,
   input  logic [3:0]                   data_i,
   output logic [3:0]                   data_o,
   output logic [3:0]                   oe_o,
   input  logic                         load_en_i,
   input  logic [$clog2(MEM_DEPTH)-1:0] load_addr_i,
   input  logic [7:0]                   load_data_i,
   output logic [7:0]                   cmd_o,
   output logic                         busy_o
);

   localparam int AW    = $clog2(MEM_DEPTH);
   localparam int CNT_W = 8;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      CMD     = 3'd1,
      ADDR    = 3'd2,
      DUMMY   = 3'd3,
      RD_DATA = 3'd4,
      WR_DATA = 3'd5,
      IGNORE  = 3'd6
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         cs_sync_q, sclk_sync_q, din_sync_q;
   logic               cs_prev_q, sclk_prev_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [7:0]         cmd_q, cmd_d;
   logic [6:0]         cmd_sh_q, cmd_sh_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [7:0]         byte_q, byte_d;
   logic [3:0]         data_q, data_d;
   logic [3:0]         oe_q, oe_d;
   logic [7:0]         mem_q [MEM_DEPTH];

   logic               cs_s, sclk_s, din_s, rise_s, fall_s, cs_fall_s;
   logic [7:0]         rd_byte_s, cur_byte_s;
   logic [1:0]         lanes_s;
   logic [3:0]         oe_mode_s;
   logic               mem_we_s;
   logic [AW-1:0]      mem_wa_s;
   logic [7:0]         mem_wd_s;
   logic               unused_s;

   function automatic logic cmd_accepted(input logic [7:0] c);
      logic ok;
      case (c)
         8'h03, 8'h3B, 8'h6B: ok = 1'b1;
`ifdef XSPI_TGT_WRITE_EN
         8'h02:               ok = 1'b1;
`endif
         default:             ok = 1'b0;
      endcase
      return ok;
   endfunction

   assign cs_s      = cs_sync_q[1];
   assign sclk_s    = sclk_sync_q[1];
   assign din_s     = din_sync_q[1];
   assign rise_s    = sclk_s & ~sclk_prev_q;
   assign fall_s    = ~sclk_s & sclk_prev_q;
   assign cs_fall_s = cs_prev_q & ~cs_s;
   assign rd_byte_s = mem_q[addr_q];
   assign unused_s  = ^data_i[3:1];

   assign data_o = data_q;
   assign oe_o   = oe_q;
   assign cmd_o  = cmd_q;
   assign busy_o = (state_q != IDLE);

   // Read lane width and output-enable pattern of the current command
   always_comb begin
      lanes_s   = 2'd0;
      oe_mode_s = 4'b0010;
      case (cmd_q)
         8'h3B:   begin lanes_s = 2'd1; oe_mode_s = 4'b0011; end
         8'h6B:   begin lanes_s = 2'd2; oe_mode_s = 4'b1111; end
         default: begin lanes_s = 2'd0; oe_mode_s = 4'b0010; end
      endcase
   end

   // Next-state, datapath and memory write decode
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      cmd_d      = cmd_q;
      cmd_sh_d   = cmd_sh_q;
      addr_d     = addr_q;
      byte_d     = byte_q;
      data_d     = data_q;
      oe_d       = oe_q;
      cur_byte_s = (cnt_q == {CNT_W{1'b0}}) ? rd_byte_s : byte_q;
      mem_we_s   = load_en_i & cs_i & cs_s;
      mem_wa_s   = load_addr_i;
      mem_wd_s   = load_data_i;
      if ((state_q != IDLE) && cs_s) begin
         // cs released: drop any partial byte and quiet the bus
         state_d = IDLE;
         cnt_d   = {CNT_W{1'b0}};
         data_d  = 4'b0000;
         oe_d    = 4'b0000;
      end else begin
         case (state_q)
            IDLE: begin
               data_d = 4'b0000;
               oe_d   = 4'b0000;
               if (cs_fall_s) begin
                  state_d = CMD;
                  cnt_d   = {CNT_W{1'b0}};
               end else begin
                  state_d = IDLE;
               end
            end
            CMD: begin
               if (rise_s) begin
                  cmd_sh_d = {cmd_sh_q[5:0], din_s};
                  if (cnt_q == CNT_W'(7)) begin
                     cmd_d   = {cmd_sh_q, din_s};
                     cnt_d   = {CNT_W{1'b0}};
                     addr_d  = {AW{1'b0}};
                     state_d = cmd_accepted({cmd_sh_q, din_s}) ? ADDR : IGNORE;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            ADDR: begin
               if (rise_s) begin
                  // Only the low AW bits survive the shift: address is taken modulo MEM_DEPTH
                  addr_d = AW'({addr_q, din_s});
                  if (cnt_q == CNT_W'(ADDR_W - 1)) begin
                     cnt_d = {CNT_W{1'b0}};
                     case (cmd_q)
                        8'h03:        begin state_d = RD_DATA; oe_d = oe_mode_s; end
                        8'h3B, 8'h6B: state_d = DUMMY;
`ifdef XSPI_TGT_WRITE_EN
                        8'h02:        state_d = WR_DATA;
`endif
                        default:      state_d = IGNORE;
                     endcase
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            DUMMY: begin
               oe_d = 4'b0000;
               if (rise_s) begin
                  if (cnt_q == CNT_W'(DUMMY_CYCLES - 1)) begin
                     cnt_d   = {CNT_W{1'b0}};
                     state_d = RD_DATA;
                     oe_d    = oe_mode_s;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            RD_DATA: begin
               oe_d = oe_mode_s;
               if (fall_s) begin
                  case (lanes_s)
                     2'd1: begin
                        data_d = {2'b00, cur_byte_s[7:6]};
                        byte_d = {cur_byte_s[5:0], 2'b00};
                        cnt_d  = cnt_q + CNT_W'(2);
                     end
                     2'd2: begin
                        data_d = cur_byte_s[7:4];
                        byte_d = {cur_byte_s[3:0], 4'b0000};
                        cnt_d  = cnt_q + CNT_W'(4);
                     end
                     default: begin
                        data_d = {2'b00, cur_byte_s[7], 1'b0};
                        byte_d = {cur_byte_s[6:0], 1'b0};
                        cnt_d  = cnt_q + CNT_W'(1);
                     end
                  endcase
                  if (cnt_d == CNT_W'(8)) begin
                     cnt_d  = {CNT_W{1'b0}};
                     addr_d = addr_q + AW'(1);
                  end else begin
                     addr_d = addr_q;
                  end
               end else begin
                  data_d = data_q;
               end
            end
`ifdef XSPI_TGT_WRITE_EN
            WR_DATA: begin
               oe_d = 4'b0000;
               if (rise_s) begin
                  byte_d = {byte_q[6:0], din_s};
                  if (cnt_q == CNT_W'(7)) begin
                     mem_we_s = 1'b1;
                     mem_wa_s = addr_q;
                     mem_wd_s = {byte_q[6:0], din_s};
                     addr_d   = addr_q + AW'(1);
                     cnt_d    = {CNT_W{1'b0}};
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
`endif
            IGNORE: begin
               data_d = 4'b0000;
               oe_d   = 4'b0000;
            end
            default: begin
               state_d = IDLE;
               data_d  = 4'b0000;
               oe_d    = 4'b0000;
            end
         endcase
      end
   end

   // Synchronizers, edge history and FSM/datapath registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cs_sync_q   <= 2'b11;
         sclk_sync_q <= 2'b00;
         din_sync_q  <= 2'b00;
         cs_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b0;
         state_q     <= IDLE;
         cnt_q       <= {CNT_W{1'b0}};
         cmd_q       <= 8'h00;
         cmd_sh_q    <= 7'h00;
         addr_q      <= {AW{1'b0}};
         byte_q      <= 8'h00;
         data_q      <= 4'b0000;
         oe_q        <= 4'b0000;
      end else begin
         cs_sync_q   <= {cs_sync_q[0], cs_i};
         sclk_sync_q <= {sclk_sync_q[0], sclk_i};
         din_sync_q  <= {din_sync_q[0], data_i[0]};
         cs_prev_q   <= cs_s;
         sclk_prev_q <= sclk_s;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         cmd_q       <= cmd_d;
         cmd_sh_q    <= cmd_sh_d;
         addr_q      <= addr_d;
         byte_q      <= byte_d;
         data_q      <= data_d;
         oe_q        <= oe_d;
      end
   end

   // Storage array, deliberately not reset
   always_ff @(posedge clk_i) begin
      if (mem_we_s) begin
         mem_q[mem_wa_s] <= mem_wd_s;
      end
   end

endmodule

// File: tb/tb_xspi_flash_target.sv
// Self-checking bench for xspi_flash_target: acts as the mode-0 master and checks against
// hand-derived vectors and a byte-array reference model.
module tb_xspi_flash_target;

   localparam int HALF  = 8;
   localparam int DUMMY = 8;

   logic       clk = 1'b0;
   logic       rst_n, cs_n, sclk, load_en, busy;
   logic [3:0] data_in, data_out, oe;
   logic [7:0] load_addr, load_data, cmd;

   always #5 clk = ~clk;

   xspi_flash_target dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .cs_i        (cs_n),
      .sclk_i      (sclk),
      .data_i      (data_in),
      .data_o      (data_out),
      .oe_o        (oe),
      .load_en_i   (load_en),
      .load_addr_i (load_addr),
      .load_data_i (load_data),
      .cmd_o       (cmd),
      .busy_o      (busy)
   );

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] mem_m [256];
   logic [3:0] beat_d  [64];
   logic [3:0] beat_oe [64];
   logic [3:0] hdr_oe, dummy_oe;

   typedef struct {
      string       name;
      logic [7:0]  cmd;
      logic [23:0] addr;
      int          nb;
      logic [63:0] exp_seq;
      logic [3:0]  exp_oe;
   } vec_t;
   vec_t tbl [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic xfer(input logic mosi, output logic [3:0] d, output logic [3:0] o);
      data_in = {3'b000, mosi};
      clks(HALF);
      d = data_out;
      o = oe;
      sclk = 1'b1;
      clks(HALF);
      sclk = 1'b0;
   endtask

   task automatic send(input logic [31:0] v, input int n, output logic [3:0] oe_acc);
      logic [3:0] d, o;
      oe_acc = 4'b0000;
      for (int i = n - 1; i >= 0; i--) begin
         xfer(v[i], d, o);
         oe_acc = oe_acc | o;
      end
   endtask

   task automatic cs_low();
      cs_n = 1'b0;
      clks(HALF);
   endtask

   task automatic cs_high();
      clks(HALF);
      cs_n = 1'b1;
      clks(3);
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      clks(1);
      load_en   = 1'b0;
      mem_m[a]  = d;
   endtask

   task automatic read_txn(input logic [7:0] c, input logic [23:0] a, input int nb);
      logic [3:0] acc;
      cs_low();
      send({24'h0, c}, 8, acc);
      hdr_oe = acc;
      send({8'h0, a}, 24, acc);
      hdr_oe   = hdr_oe | acc;
      dummy_oe = 4'b0000;
      if (c != 8'h03) send($urandom, DUMMY, dummy_oe);
      for (int i = 0; i < nb; i++) xfer(1'b0, beat_d[i], beat_oe[i]);
      cs_high();
   endtask

   task automatic check_idle(input string name);
      check({name, " oe"}, 32'(oe), 32'h0);
      check({name, " busy"}, 32'(busy), 32'h0);
      check({name, " data"}, 32'(data_out), 32'h0);
   endtask

   // Reference: beat k of a read carries bit positions k*w .. k*w+w-1 of the byte stream from addr
   function automatic logic [3:0] model_beat(input logic [7:0] c, input logic [23:0] a, input int k);
      int w, bp, idx, v;
      w   = (c == 8'h03) ? 1 : ((c == 8'h3B) ? 2 : 4);
      bp  = k * w;
      idx = (int'(a) + bp / 8) % 256;
      v   = (int'(mem_m[idx]) >> (8 - w - bp % 8)) & ((1 << w) - 1);
      if (w == 1) v = v << 1;
      return v[3:0];
   endfunction

   function automatic logic [3:0] model_oe(input logic [7:0] c);
      return (c == 8'h03) ? 4'b0010 : ((c == 8'h3B) ? 4'b0011 : 4'b1111);
   endfunction

   task automatic check_model(input string name, input logic [7:0] c, input logic [23:0] a, input int nb);
      for (int i = 0; i < nb; i++) begin
         check($sformatf("%s beat%0d", name, i), 32'(beat_d[i]), 32'(model_beat(c, a, i)));
         check($sformatf("%s oe%0d", name, i), 32'(beat_oe[i]), 32'(model_oe(c)));
      end
   endtask

   initial begin
      #900_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [3:0] acc;
      logic [7:0] got, exp0, exp1;
      logic [7:0] rcmds [3];
      logic [7:0] c;
      logic [23:0] a;
      int nb;

      rcmds = '{8'h03, 8'h3B, 8'h6B};
      tbl[0] = '{"single_10",   8'h03, 24'h000010, 16, 64'h2020_0202_0022_2200, 4'b0010};
      tbl[1] = '{"quad_10",     8'h6B, 24'h000010,  4, 64'hA53C_0000_0000_0000, 4'b1111};
      tbl[2] = '{"dual_wrap",   8'h3B, 24'h0000FF,  8, 64'h2001_1332_0000_0000, 4'b0011};
      tbl[3] = '{"single_wrap", 8'h03, 24'h0000FF, 16, 64'h2000_0002_0222_2220, 4'b0010};
      tbl[4] = '{"quad_hiaddr", 8'h6B, 24'hAB12FF,  4, 64'h817E_0000_0000_0000, 4'b1111};

      rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; data_in = 4'h0;
      load_en = 1'b0; load_addr = 8'h00; load_data = 8'h00;
      clks(3);
      check("reset data_o", 32'(data_out), 32'h0);
      check("reset oe_o", 32'(oe), 32'h0);
      check("reset cmd_o", 32'(cmd), 32'h0);
      check("reset busy_o", 32'(busy), 32'h0);
      rst_n = 1'b1;
      clks(4);

      for (int i = 0; i < 256; i++) load(8'(i), 8'($urandom));
      load(8'h10, 8'hA5); load(8'h11, 8'h3C);
      load(8'hFF, 8'h81); load(8'h00, 8'h7E);
      load(8'h20, 8'h5A); load(8'h21, 8'h69);

      // Unknown command: silent until cs rises; a backdoor load during cs low must not land
      cs_low();
      send(32'h9F, 8, acc);
      load_en = 1'b1; load_addr = 8'h10; load_data = 8'hFF;
      clks(1);
      load_en = 1'b0;
      send($urandom, 32, acc);
      check("unk oe", 32'(acc), 32'h0);
      check("unk cmd_o", 32'(cmd), 32'h9F);
      check("unk busy", 32'(busy), 32'h1);
      cs_high();
      check_idle("unk end");
      clks(5);

      for (int t = 0; t < 5; t++) begin
         read_txn(tbl[t].cmd, tbl[t].addr, tbl[t].nb);
         check({tbl[t].name, " hdr_oe"}, 32'(hdr_oe), 32'h0);
         if (tbl[t].cmd != 8'h03) check({tbl[t].name, " dummy_oe"}, 32'(dummy_oe), 32'h0);
         check({tbl[t].name, " cmd_o"}, 32'(cmd), 32'(tbl[t].cmd));
         for (int i = 0; i < tbl[t].nb; i++) begin
            check($sformatf("%s beat%0d", tbl[t].name, i), 32'(beat_d[i]),
                  32'(tbl[t].exp_seq[63 - 4 * i -: 4]));
            check($sformatf("%s oe%0d", tbl[t].name, i), 32'(beat_oe[i]), 32'(tbl[t].exp_oe));
         end
         check_idle({tbl[t].name, " end"});
         clks(5);
      end

      // Abort after 4 bits, then a fresh read from the same address restarts at bit 7
      read_txn(8'h03, 24'h000010, 4);
      check_model("abort", 8'h03, 24'h000010, 4);
      check_idle("abort end");
      clks(5);
      read_txn(8'h03, 24'h000010, 16);
      check_model("restart", 8'h03, 24'h000010, 16);
      clks(5);

      // Page program then read back
      cs_low();
      send(32'h02, 8, acc);
      send(32'h000020, 24, acc);
      send(32'hDE, 8, acc);
      send(32'hAD, 8, acc);
      check("wr oe", 32'(acc), 32'h0);
      cs_high();
      check_idle("wr end");
`ifdef XSPI_TGT_WRITE_EN
      mem_m[8'h20] = 8'hDE;
      mem_m[8'h21] = 8'hAD;
      exp0 = 8'hDE; exp1 = 8'hAD;
`else
      exp0 = 8'h5A; exp1 = 8'h69;
`endif
      clks(5);
      read_txn(8'h03, 24'h000020, 16);
      got = 8'h00;
      for (int i = 0; i < 8; i++) got = {got[6:0], beat_d[i][1]};
      check("wr readback byte0", 32'(got), 32'(exp0));
      got = 8'h00;
      for (int i = 8; i < 16; i++) got = {got[6:0], beat_d[i][1]};
      check("wr readback byte1", 32'(got), 32'(exp1));
      clks(5);

      // Randomised reads against the byte-array model
      for (int r = 0; r < 20; r++) begin
         for (int j = 0; j < int'($urandom_range(0, 3)); j++) load(8'($urandom), 8'($urandom));
         c  = rcmds[$urandom_range(0, 2)];
         a  = 24'($urandom);
         nb = $urandom_range(1, 20);
         read_txn(c, a, nb);
         check($sformatf("rnd%0d hdr_oe", r), 32'(hdr_oe), 32'h0);
         check_model($sformatf("rnd%0d", r), c, a, nb);
         check_idle($sformatf("rnd%0d end", r));
         clks(5);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
